// File: rtl/vid_timing_rx.sv
// rtl/vid_timing_rx.sv - video timing receiver: measures frame geometry, checks stability, reports lock.
// Optional VRX_CHECKSUM_EN adds a per-frame {R,G,B} mod-256 pixel checksum output.
module vid_timing_rx #(
  parameter int CW          = 16,
  parameter int EXP_HACT    = 640,
  parameter int EXP_VACT    = 480,
  parameter int LOCK_FRAMES = 4
) (
  input  logic          px_clk,
  input  logic          sys_rst_n,
  input  logic          vsync_i,
  input  logic          hsync_i,
  input  logic          dval_i,
  input  logic [7:0]    rdata_i,
  input  logic [7:0]    gdata_i,
  input  logic [7:0]    bdata_i,
  output logic [CW-1:0] hact_o,
  output logic [CW-1:0] vact_o,
  output logic [CW-1:0] htotal_o,
  output logic [CW-1:0] vtotal_o,
  output logic          frame_done_o,
  output logic          locked_o,
  output logic          fmt_ok_o,
`ifdef VRX_CHECKSUM_EN
  output logic [23:0]   checksum_o,
`endif
  output logic          err_o
);

  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          vs_s1_q, vs_s2_q, hs_s1_q, hs_s2_q, dv_s1_q;
  logic          vs_rise, hs_rise;
  logic [CW-1:0] htot_cnt_q, htot_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] vtot_cnt_q, vtot_cnt_d, vact_cnt_q, vact_cnt_d;
  logic [CW-1:0] pix_ref_q, pix_ref_d, htot_ref_q, htot_ref_d;
  logic          pix_ref_set_q, pix_ref_set_d, htot_ref_set_q, htot_ref_set_d;
  logic          line_err_q, line_err_d;
  logic [CW-1:0] ref_hact_q, ref_hact_d, ref_vact_q, ref_vact_d;
  logic [CW-1:0] ref_htot_q, ref_htot_d, ref_vtot_q, ref_vtot_d;
  logic [CW-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic [CW-1:0] hact_q, hact_d, vact_q, vact_d, htotal_q, htotal_d, vtotal_q, vtotal_d;
  logic          done_q, done_d, locked_q, locked_d, fmt_ok_q, fmt_ok_d, err_q, err_d;
  logic          pix_nz, pix_bad, htot_use, htot_bad, meas_err, match;
  logic [CW-1:0] meas_hact, meas_vact, meas_htot;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  assign vs_rise = vs_s1_q & ~vs_s2_q;
  assign hs_rise = hs_s1_q & ~hs_s2_q;

  always_comb begin
    // Closing the open line; a line's period only counts if it began inside this frame.
    pix_nz    = (pix_cnt_q != '0);
    pix_bad   = pix_nz && pix_ref_set_q && (pix_cnt_q != pix_ref_q);
    htot_use  = hs_rise && (vtot_cnt_q != '0);
    htot_bad  = htot_use && htot_ref_set_q && (htot_cnt_q != htot_ref_q);
    meas_err  = line_err_q | pix_bad | htot_bad;
    meas_hact = pix_ref_set_q ? pix_ref_q : pix_cnt_q;
    meas_vact = pix_nz ? sat_inc(vact_cnt_q) : vact_cnt_q;
    meas_htot = htot_ref_set_q ? htot_ref_q : (htot_use ? htot_cnt_q : '0);
    match     = (meas_hact == ref_hact_q) && (meas_vact == ref_vact_q) &&
                (meas_htot == ref_htot_q) && (vtot_cnt_q == ref_vtot_q) && !meas_err;
    good_inc  = good_cnt_q + CW'(1);

    state_d        = state_q;
    htot_cnt_d     = hs_rise ? CW'(1) : sat_inc(htot_cnt_q);
    pix_cnt_d      = pix_cnt_q;
    vtot_cnt_d     = vtot_cnt_q;
    vact_cnt_d     = vact_cnt_q;
    pix_ref_d      = pix_ref_q;
    pix_ref_set_d  = pix_ref_set_q;
    htot_ref_d     = htot_ref_q;
    htot_ref_set_d = htot_ref_set_q;
    line_err_d     = line_err_q;
    ref_hact_d     = ref_hact_q;
    ref_vact_d     = ref_vact_q;
    ref_htot_d     = ref_htot_q;
    ref_vtot_d     = ref_vtot_q;
    good_cnt_d     = good_cnt_q;
    hact_d         = hact_q;
    vact_d         = vact_q;
    htotal_d       = htotal_q;
    vtotal_d       = vtotal_q;
    fmt_ok_d       = fmt_ok_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    if (vs_rise) begin
      // Old frame is closed above; a coincident hsync rise opens line 1 of the new one.
      htot_cnt_d     = hs_rise ? CW'(1) : '0;
      vtot_cnt_d     = hs_rise ? CW'(1) : '0;
      pix_cnt_d      = dv_s1_q ? CW'(1) : '0;
      vact_cnt_d     = '0;
      pix_ref_d      = '0;
      pix_ref_set_d  = 1'b0;
      htot_ref_d     = '0;
      htot_ref_set_d = 1'b0;
      line_err_d     = 1'b0;
    end else if (hs_rise) begin
      vtot_cnt_d = sat_inc(vtot_cnt_q);
      vact_cnt_d = meas_vact;
      line_err_d = meas_err;
      pix_cnt_d  = dv_s1_q ? CW'(1) : '0;
      if (!pix_ref_set_q && pix_nz) begin
        pix_ref_d     = pix_cnt_q;
        pix_ref_set_d = 1'b1;
      end
      if (htot_use && !htot_ref_set_q) begin
        htot_ref_d     = htot_cnt_q;
        htot_ref_set_d = 1'b1;
      end
    end else if (dv_s1_q) begin
      pix_cnt_d = sat_inc(pix_cnt_q);
    end

    case (state_q)
      IDLE: if (vs_rise) state_d = ACQ;
      ACQ: if (vs_rise) begin
        good_cnt_d = CW'(1);
        state_d    = (LOCK_FRAMES <= 1) ? LOCKED : TRACK;
      end
      TRACK: if (vs_rise) begin
        if (match) begin
          good_cnt_d = good_inc;
          if (good_inc >= LOCK_N) state_d = LOCKED;
        end else begin
          err_d      = 1'b1;
          good_cnt_d = CW'(1);
        end
      end
      default: begin
        if (vs_rise) begin
          if (!match) begin
            err_d   = 1'b1;
            state_d = ACQ;
          end
        end else if (vtot_cnt_q == CMAX) begin
          err_d   = 1'b1;
          state_d = ACQ;
        end
      end
    endcase

    if (vs_rise && state_q != IDLE) begin
      done_d     = 1'b1;
      hact_d     = meas_hact;
      vact_d     = meas_vact;
      htotal_d   = meas_htot;
      vtotal_d   = vtot_cnt_q;
      fmt_ok_d   = (meas_hact == CW'(EXP_HACT)) && (meas_vact == CW'(EXP_VACT));
      ref_hact_d = meas_hact;
      ref_vact_d = meas_vact;
      ref_htot_d = meas_htot;
      ref_vtot_d = vtot_cnt_q;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      {vs_s1_q, vs_s2_q, hs_s1_q, hs_s2_q, dv_s1_q} <= '0;
      htot_cnt_q <= '0; pix_cnt_q <= '0; vtot_cnt_q <= '0; vact_cnt_q <= '0;
      pix_ref_q <= '0; htot_ref_q <= '0; pix_ref_set_q <= 1'b0; htot_ref_set_q <= 1'b0;
      line_err_q <= 1'b0; good_cnt_q <= '0;
      ref_hact_q <= '0; ref_vact_q <= '0; ref_htot_q <= '0; ref_vtot_q <= '0;
      hact_q <= '0; vact_q <= '0; htotal_q <= '0; vtotal_q <= '0;
      done_q <= 1'b0; locked_q <= 1'b0; fmt_ok_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_s1_q <= vsync_i; vs_s2_q <= vs_s1_q;
      hs_s1_q <= hsync_i; hs_s2_q <= hs_s1_q;
      dv_s1_q <= dval_i;
      htot_cnt_q <= htot_cnt_d; pix_cnt_q <= pix_cnt_d;
      vtot_cnt_q <= vtot_cnt_d; vact_cnt_q <= vact_cnt_d;
      pix_ref_q <= pix_ref_d; htot_ref_q <= htot_ref_d;
      pix_ref_set_q <= pix_ref_set_d; htot_ref_set_q <= htot_ref_set_d;
      line_err_q <= line_err_d; good_cnt_q <= good_cnt_d;
      ref_hact_q <= ref_hact_d; ref_vact_q <= ref_vact_d;
      ref_htot_q <= ref_htot_d; ref_vtot_q <= ref_vtot_d;
      hact_q <= hact_d; vact_q <= vact_d; htotal_q <= htotal_d; vtotal_q <= vtotal_d;
      done_q <= done_d; locked_q <= locked_d; fmt_ok_q <= fmt_ok_d; err_q <= err_d;
    end
  end

  assign hact_o       = hact_q;
  assign vact_o       = vact_q;
  assign htotal_o     = htotal_q;
  assign vtotal_o     = vtotal_q;
  assign frame_done_o = done_q;
  assign locked_o     = locked_q;
  assign fmt_ok_o     = fmt_ok_q;
  assign err_o        = err_q;

`ifdef VRX_CHECKSUM_EN
  logic [7:0]  r_s1_q, g_s1_q, b_s1_q;
  logic [7:0]  sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic [23:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    sum_r_d    = sum_r_q;
    sum_g_d    = sum_g_q;
    sum_b_d    = sum_b_q;
    if (vs_rise && state_q != IDLE) checksum_d = {sum_r_q, sum_g_q, sum_b_q};
    if (vs_rise) begin
      sum_r_d = dv_s1_q ? r_s1_q : 8'd0;
      sum_g_d = dv_s1_q ? g_s1_q : 8'd0;
      sum_b_d = dv_s1_q ? b_s1_q : 8'd0;
    end else if (dv_s1_q) begin
      sum_r_d = sum_r_q + r_s1_q;
      sum_g_d = sum_g_q + g_s1_q;
      sum_b_d = sum_b_q + b_s1_q;
    end
  end

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {r_s1_q, g_s1_q, b_s1_q} <= '0;
      {sum_r_q, sum_g_q, sum_b_q} <= '0;
      checksum_q <= '0;
    end else begin
      r_s1_q <= rdata_i; g_s1_q <= gdata_i; b_s1_q <= bdata_i;
      sum_r_q <= sum_r_d; sum_g_q <= sum_g_d; sum_b_q <= sum_b_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  logic unused_px;
  assign unused_px = ^{rdata_i, gdata_i, bdata_i};
`endif

endmodule

// File: tb/tb_vid_timing_rx.sv
// tb/tb_vid_timing_rx.sv - directed bench for vid_timing_rx on a scaled 16x12 (24x16 total) raster.
module tb_vid_timing_rx;
  localparam int CW  = 16;
  localparam int HT  = 24;
  localparam int VT  = 16;
  localparam int HS0 = 6;
  localparam int VS0 = 2;
  localparam int EH  = 16;
  localparam int EV  = 12;

  logic          px_clk = 1'b0;
  logic          sys_rst_n;
  logic          vsync_i, hsync_i, dval_i;
  logic [7:0]    rdata_i, gdata_i, bdata_i;
  logic [CW-1:0] hact_o, vact_o, htotal_o, vtotal_o;
  logic          frame_done_o, locked_o, fmt_ok_o, err_o;
`ifdef VRX_CHECKSUM_EN
  logic [23:0]   checksum_o;
  logic [23:0]   s_ck;
`endif

  int            checks = 0;
  int            errors = 0;
  int            n_done = 0;
  int            n_err  = 0;
  logic [CW-1:0] s_hact, s_vact, s_htot, s_vtot;
  logic          s_fmt, s_lock, s_err, s_lock3;

  always #5 px_clk = ~px_clk;

  vid_timing_rx #(.CW(CW), .EXP_HACT(EH), .EXP_VACT(EV), .LOCK_FRAMES(4)) dut (
    .px_clk(px_clk), .sys_rst_n(sys_rst_n),
    .vsync_i(vsync_i), .hsync_i(hsync_i), .dval_i(dval_i),
    .rdata_i(rdata_i), .gdata_i(gdata_i), .bdata_i(bdata_i),
    .hact_o(hact_o), .vact_o(vact_o), .htotal_o(htotal_o), .vtotal_o(vtotal_o),
    .frame_done_o(frame_done_o), .locked_o(locked_o), .fmt_ok_o(fmt_ok_o),
`ifdef VRX_CHECKSUM_EN
    .checksum_o(checksum_o),
`endif
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hs, input logic dv);
    vsync_i = vs; hsync_i = hs; dval_i = dv;
    rdata_i = 8'd1; gdata_i = 8'd2; bdata_i = 8'd3;
    @(posedge px_clk);
    @(negedge px_clk);
    if (frame_done_o) begin
      n_done++;
      s_hact = hact_o; s_vact = vact_o; s_htot = htotal_o; s_vtot = vtotal_o;
      s_fmt = fmt_ok_o; s_lock = locked_o; s_err = err_o;
      if (n_done == 3) s_lock3 = locked_o;
`ifdef VRX_CHECKSUM_EN
      s_ck = checksum_o;
`endif
    end
    if (err_o) n_err++;
  endtask

  task automatic drive_lines(input int hact, input int vact, input int short_l, input int l0, input int l1);
    for (int l = l0; l < l1; l++) begin
      for (int c = 0; c < HT; c++) begin
        int w;
        w = (l == short_l) ? hact - 1 : hact;
        cyc(l < 2, c < 4, (l >= VS0) && (l < VS0 + vact) && (c >= HS0) && (c < HS0 + w));
      end
    end
  endtask

  task automatic frame(input int hact, input int vact, input int short_l);
    drive_lines(hact, vact, short_l, 0, VT);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    vsync_i = 1'b0; hsync_i = 1'b0; dval_i = 1'b0;
    rdata_i = '0; gdata_i = '0; bdata_i = '0;
    s_lock3 = 1'b0;
    repeat (2) @(negedge px_clk);
    chk("rst_hact", 32'(hact_o), 32'd0);
    chk("rst_flags", {28'd0, frame_done_o, locked_o, fmt_ok_o, err_o}, 32'd0);
    sys_rst_n = 1'b1;

    frame(EH, EV, -1);
    frame(EH, EV, -1);
    drive_lines(EH, EV, -1, 0, 7);
    chk("pre_rst_hact", 32'(hact_o), EH);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_meas", {hact_o, vact_o}, 32'd0);
    chk("async_rst_tot", {htotal_o, vtotal_o}, 32'd0);
    chk("async_rst_flags", {28'd0, frame_done_o, locked_o, fmt_ok_o, err_o}, 32'd0);
    @(negedge px_clk);
    sys_rst_n = 1'b1;
    n_done = 0; n_err = 0;

    drive_lines(EH, EV, -1, 7, VT);
    frame(EH, EV, -1);
    chk("idle_no_done", n_done, 0);
    frame(EH, EV, -1);
    chk("first_done", n_done, 1);
    chk("hact", 32'(s_hact), EH);
    chk("vact", 32'(s_vact), EV);
    chk("htotal", 32'(s_htot), HT);
    chk("vtotal", 32'(s_vtot), VT);
    chk("fmt_ok", 32'(s_fmt), 1);
    chk("first_unlocked", 32'(s_lock), 0);
`ifdef VRX_CHECKSUM_EN
    chk("checksum_full", s_ck, 24'hC08040);
`endif

    frame(EH, EV, -1);
    frame(EH, EV, -1);
    frame(EH, EV, -1);
    chk("done_cnt", n_done, 4);
    chk("unlocked_3rd", 32'(s_lock3), 0);
    chk("lock_4th", 32'(s_lock), 1);
    chk("steady_no_err", n_err, 0);

    frame(EH, EV, -1);
    frame(EH, EV, 5);
    frame(EH, EV, -1);
    chk("short_err_cnt", n_err, 1);
    chk("short_err_at_done", 32'(s_err), 1);
    chk("short_unlock", 32'(s_lock), 0);
    frame(EH, EV, -1);
    frame(EH, EV, -1);
    frame(EH, EV, -1);
    chk("relock_wait", 32'(locked_o), 0);
    frame(EH, EV, -1);
    chk("relock", 32'(locked_o), 1);
    chk("relock_vtotal", 32'(s_vtot), VT);
    chk("relock_err_cnt", n_err, 1);

    for (int f = 0; f < 6; f++) frame(EH / 2, EV / 2, -1);
    chk("half_locked", 32'(locked_o), 1);
    chk("half_hact", 32'(s_hact), EH / 2);
    chk("half_vact", 32'(s_vact), EV / 2);
    chk("half_fmt", 32'(s_fmt), 0);
    chk("half_htotal", 32'(s_htot), HT);
    chk("half_err_cnt", n_err, 2);
`ifdef VRX_CHECKSUM_EN
    chk("checksum_half", s_ck, 24'h306090);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
